// File: rtl/alu_issuer.sv
// alu_issuer: queues instruction words and issues them one at a time to the
// ALU, returning each result (or a timeout) over a valid/ready port.
module alu_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  opcode,
  output logic [2:0]  registro,
  output logic        posicion,
  output logic [7:0]  datos,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [3:0]  alu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_data,
  output logic [2:0]  res_opcode,
  output logic        res_timeout,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] LP_TMO  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REPORT
  } state_t;

  logic [14:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [TW-1:0] r_wcnt;
  logic [2:0]    r_opcode;
  logic [2:0]    r_registro;
  logic          r_posicion;
  logic [7:0]    r_datos;
  logic          r_start;
  logic          r_res_valid;
  logic [3:0]    r_res_data;
  logic [2:0]    r_res_opcode;
  logic          r_res_timeout;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [14:0]   w_head;
  logic [TW-1:0] w_wcnt_nxt;

  assign w_full     = (r_count == LP_FULL);
  assign w_push     = instr_valid && !w_full;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_head     = r_mem[r_rptr];
  assign w_wcnt_nxt = r_wcnt + 1'b1;

  assign instr_ready = !w_full;
  assign opcode      = r_opcode;
  assign registro    = r_registro;
  assign posicion    = r_posicion;
  assign datos       = r_datos;
  assign alu_start   = r_start;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_opcode  = r_res_opcode;
  assign res_timeout = r_res_timeout;
  assign busy        = (r_state != S_IDLE) || (r_count != '0);

  // Storage array needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      r_opcode      <= '0;
      r_registro    <= '0;
      r_posicion    <= 1'b0;
      r_datos       <= '0;
      r_start       <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_opcode  <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_opcode   <= w_head[14:12];
            r_registro <= w_head[11:9];
            r_posicion <= w_head[8];
            r_datos    <= w_head[7:0];
            r_wcnt     <= '0;
            r_start    <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          // done is tested first so it wins over the terminal count
          if (alu_done) begin
            r_res_data    <= alu_result;
            r_res_timeout <= 1'b0;
            r_res_opcode  <= r_opcode;
            r_res_valid   <= 1'b1;
            r_state       <= S_REPORT;
          end else if (w_wcnt_nxt == LP_TMO) begin
            r_wcnt        <= w_wcnt_nxt;
            r_res_data    <= '0;
            r_res_timeout <= 1'b1;
            r_res_opcode  <= r_opcode;
            r_res_valid   <= 1'b1;
            r_state       <= S_REPORT;
          end else begin
            r_wcnt <= w_wcnt_nxt;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: directed vectors for alu_issuer with hand-computed
// expectations for issue, queueing, timeout, backpressure and reset.
module tb_alu_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  opcode;
  logic [2:0]  registro;
  logic        posicion;
  logic [7:0]  datos;
  logic        alu_start;
  logic        alu_done;
  logic [3:0]  alu_result;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_data;
  logic [2:0]  res_opcode;
  logic        res_timeout;
  logic        busy;

  int n_chk    = 0;
  int n_pass   = 0;
  int n_starts = 0;

  alu_issuer #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode(opcode), .registro(registro),
    .posicion(posicion), .datos(datos),
    .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_opcode(res_opcode),
    .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (alu_start === 1'b1) n_starts++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  function automatic logic [14:0] mk(input logic [2:0] op,
                                     input logic [2:0] rg,
                                     input logic       ps,
                                     input logic [7:0] dt);
    return {op, rg, ps, dt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int i = 0;
    while (alu_start !== 1'b1 && i < 40) begin
      tick();
      i++;
    end
    check({tag, " start"}, 32'(alu_start), 1);
  endtask

  task automatic serve(input logic [14:0] e,
                       input logic [3:0]  r,
                       input string       tag);
    wait_start(tag);
    check({tag, " ops"},
          32'({opcode, registro, posicion, datos}), 32'(e));
    tick();
    alu_done   = 1'b1;
    alu_result = r;
    tick();
    alu_done   = 1'b0;
    check({tag, " valid"}, 32'(res_valid), 1);
    check({tag, " data"}, 32'(res_data), 32'(r));
    check({tag, " ropc"}, 32'(res_opcode), 32'(e[14:12]));
    check({tag, " tmo"}, 32'(res_timeout), 0);
  endtask

  function automatic logic [31:0] outs();
    return 32'({opcode, registro, posicion, datos, alu_start,
                res_valid, res_data, res_opcode, res_timeout, busy});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] q [5];
    logic [14:0] x;
    logic [14:0] y;
    int s;

    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    alu_done = 1'b0;
    alu_result = '0;
    res_ready = 1'b0;
    repeat (2) tick();
    check("rst outs", outs(), 0);
    rst = 1'b0;
    tick();
    check("rst ready", 32'(instr_ready), 1);

    // single suma
    s = n_starts;
    res_ready = 1'b1;
    instr = mk(3'd0, 3'd0, 1'b0, 8'h2A);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("t1 nostart", 32'(alu_start), 0);
    check("t1 busy", 32'(busy), 1);
    tick();
    check("t1 start", 32'(alu_start), 1);
    check("t1 opc", 32'(opcode), 0);
    check("t1 datos", 32'(datos), 32'h2A);
    tick();
    check("t1 pulse", 32'(alu_start), 0);
    tick();
    alu_done = 1'b1;
    alu_result = 4'h9;
    tick();
    alu_done = 1'b0;
    check("t1 valid", 32'(res_valid), 1);
    check("t1 data", 32'(res_data), 9);
    check("t1 ropc", 32'(res_opcode), 0);
    check("t1 tmo", 32'(res_timeout), 0);
    tick();
    check("t1 drop", 32'(res_valid), 0);
    check("t1 idle", 32'(busy), 0);
    check("t1 nstart", 32'(n_starts - s), 1);

    // FIFO full
    res_ready = 1'b0;
    q[0] = mk(3'd1, 3'd2, 1'b1, 8'h11);
    q[1] = mk(3'd2, 3'd3, 1'b0, 8'h22);
    q[2] = mk(3'd6, 3'd4, 1'b1, 8'h33);
    q[3] = mk(3'd7, 3'd5, 1'b0, 8'h44);
    q[4] = mk(3'd3, 3'd6, 1'b1, 8'h55);
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr = q[i];
      tick();
    end
    check("full ready", 32'(instr_ready), 0);
    check("full busy", 32'(busy), 1);
    check("full ops",
          32'({opcode, registro, posicion, datos}), 32'(q[0]));
    instr = mk(3'd4, 3'd7, 1'b1, 8'h66);
    tick();
    instr_valid = 1'b0;
    check("full 6th", 32'(instr_ready), 0);
    res_ready = 1'b1;
    alu_done = 1'b1;
    alu_result = 4'h1;
    tick();
    alu_done = 1'b0;
    check("full a data", 32'(res_data), 1);
    check("full a ropc", 32'(res_opcode), 1);
    serve(q[1], 4'h2, "full b");
    serve(q[2], 4'h3, "full c");
    serve(q[3], 4'h4, "full d");
    serve(q[4], 4'h5, "full e");
    s = n_starts;
    repeat (30) tick();
    check("full drained", 32'(n_starts - s), 0);
    check("full idle", 32'(busy), 0);

    // timeout
    res_ready = 1'b0;
    instr = mk(3'd5, 3'd1, 1'b0, 8'hA5);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    wait_start("to");
    tick();
    repeat (14) tick();
    check("to early", 32'(res_valid), 0);
    tick();
    check("to valid", 32'(res_valid), 1);
    check("to flag", 32'(res_timeout), 1);
    check("to data", 32'(res_data), 0);
    check("to ropc", 32'(res_opcode), 5);
    res_ready = 1'b1;
    tick();
    check("to drop", 32'(res_valid), 0);

    // backpressure and spurious done
    res_ready = 1'b0;
    x = mk(3'd2, 3'd1, 1'b1, 8'h0F);
    y = mk(3'd3, 3'd2, 1'b0, 8'hF0);
    instr_valid = 1'b1;
    instr = x;
    tick();
    instr = y;
    tick();
    instr_valid = 1'b0;
    serve(x, 4'h4, "bp x");
    s = n_starts;
    for (int i = 0; i < 10; i++) begin
      alu_done = (i % 2 == 0);
      alu_result = 4'hF;
      tick();
    end
    alu_done = 1'b0;
    check("bp data", 32'(res_data), 4);
    check("bp valid", 32'(res_valid), 1);
    check("bp nostart", 32'(n_starts - s), 0);
    res_ready = 1'b1;
    tick();
    check("bp rel+1", 32'(alu_start), 0);
    tick();
    check("bp rel+2", 32'(alu_start), 1);
    serve(y, 4'h6, "bp y");
    tick();

    // done and timeout on the same edge
    res_ready = 1'b0;
    instr = mk(3'd4, 3'd3, 1'b1, 8'h77);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    wait_start("co");
    tick();
    repeat (14) tick();
    alu_done = 1'b1;
    alu_result = 4'h3;
    tick();
    alu_done = 1'b0;
    check("co valid", 32'(res_valid), 1);
    check("co tmo", 32'(res_timeout), 0);
    check("co data", 32'(res_data), 3);
    res_ready = 1'b1;
    tick();

    // reset mid-WAIT with two entries queued
    instr_valid = 1'b1;
    instr = mk(3'd6, 3'd5, 1'b1, 8'h81);
    tick();
    instr = mk(3'd7, 3'd6, 1'b0, 8'h82);
    tick();
    instr = mk(3'd1, 3'd7, 1'b1, 8'h83);
    tick();
    instr_valid = 1'b0;
    tick();
    check("rw busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rw outs", outs(), 0);
    check("rw busy0", 32'(busy), 0);
    tick();
    rst = 1'b0;
    s = n_starts;
    repeat (20) tick();
    check("rw nostart", 32'(n_starts - s), 0);
    check("rw ready", 32'(instr_ready), 1);
    check("rw idle", 32'(busy), 0);
    x = mk(3'd0, 3'd1, 1'b0, 8'h5A);
    instr = x;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    serve(x, 4'hA, "rw new");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
# alu_issuer

Initiator side of the ALU command interface. Buffers incoming instruction words in a small FIFO, drives them one at a time onto the ALU operand/opcode lines with a single-cycle start strobe, waits for the selected functional unit's done pulse, and returns the 4-bit result (or a timeout flag) through a valid/ready result port. Sits between the instruction source and the ALU top, replacing direct static driving of `opcode`/`datos`/`registro`/`posicion`.

## Interface

Parameters:
- `DEPTH`, 4: instruction FIFO entries, a power of two, at least 2.
- `TIMEOUT`, 15: maximum WAIT cycles without `alu_done` before the command is abandoned, at least 1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `instr` input 15: instruction word.
  - [14:12] opcode: 0 suma, 1 complemento, 2 shift_l, 3 shift_R, 4 compc, 5 compn, 6 load, 7 save.
  - [11:9] registro.
  - [8] posicion.
  - [7:0] datos.
- `instr_valid` input 1: source offers `instr`.
- `instr_ready` output 1: FIFO not full.
- `opcode` output 3, `registro` output 3, `posicion` output 1, `datos` output 8: operand lines to the ALU.
- `alu_start` output 1: one-cycle issue strobe.
- `alu_done` input 1: completion pulse from the ALU.
- `alu_result` input 4: ALU result, valid when `alu_done` is high.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer accepts the result.
- `res_data` output 4: captured result.
- `res_opcode` output 3: opcode of the reported command.
- `res_timeout` output 1: command timed out.
- `busy` output 1: FSM not IDLE or FIFO not empty.

## Operation

- The FIFO pushes on a rising edge when `instr_valid && instr_ready`.
- `instr_ready` = !full, computed from the registered occupancy count. A push is never accepted while full.
- FSM states: IDLE, ISSUE, WAIT, REPORT.
- IDLE: if the FIFO is non-empty, pop the head at the edge, load the operand registers, clear the wait counter, and go to ISSUE.
- ISSUE: `alu_start`=1 for exactly this cycle. `alu_done` is ignored in this state. Go to WAIT unconditionally.
- WAIT: operand outputs stay stable.
  - If `alu_done`=1 at an edge: capture `alu_result` into `res_data`, set `res_timeout`=0, go to REPORT.
  - Otherwise increment the wait counter. When the counter reaches `TIMEOUT`: set `res_data`=0, `res_timeout`=1, go to REPORT.
- REPORT: `res_valid`=1. `res_data`, `res_opcode` and `res_timeout` are held. At an edge with `res_ready`=1, go to IDLE. No pop occurs on that same edge.
- All opcodes are handled identically, including save. The result is whatever the ALU presents with `alu_done`.
- `alu_done` arriving in IDLE, ISSUE or REPORT is ignored and has no side effects.
- The FIFO may push in any FSM state. A push and a pop on the same edge are both performed, and occupancy is unchanged.
- Operand outputs keep the last issued command until the next pop. They are not cleared on return to IDLE.

## Timing

- Reset (asynchronous, immediate): FSM to IDLE, FIFO emptied, wait counter 0.
  - Outputs 0: `opcode`, `registro`, `posicion`, `datos`, `alu_start`, `res_valid`, `res_data`, `res_opcode`, `res_timeout`, `busy`.
  - `instr_ready`=1 once `rst` is released.
- Reset during WAIT or REPORT abandons the command. No result is reported for it.
- Issue latency: for an instruction pushed at edge k into an empty FIFO with the FSM in IDLE:
  - `alu_start` is high between edges k+1 and k+2.
  - The earliest `alu_done` that can be sampled is at edge k+3.
- Result latency: for `alu_done` sampled at edge m, `res_valid` rises after m and data is transferred at the first edge with `res_ready`=1.
- Back-to-back throughput: minimum 4 cycles per command (IDLE, ISSUE, WAIT, REPORT with `res_ready` held at 1).
- Timeout: with `alu_done` never asserted, `res_timeout` rises after exactly `TIMEOUT` WAIT edges.
- `alu_done` and the timeout terminal count on the same edge: done wins and the result is captured.

## Test plan

- Single suma: push `instr`=0x0_0_0_2A (opcode 0, datos 0x2A), hold `res_ready`=1, return `alu_done`=1 with `alu_result`=0x9 three cycles after start.
  - Exactly one `alu_start` pulse with `opcode`=0, `datos`=0x2A.
  - `res_valid`=1, `res_data`=0x9, `res_opcode`=0, `res_timeout`=0.
- FIFO full: `res_ready`=0, no `alu_done`, push 5 instructions with `DEPTH`=4.
  - One instruction is popped and in WAIT, and the FIFO holds the remaining 4.
  - `instr_ready`=0 after the 5th push, and a 6th offer is not accepted.
- Timeout: issue opcode 5 and never assert `alu_done`.
  - After 15 WAIT edges: `res_valid`=1, `res_timeout`=1, `res_data`=0, `res_opcode`=5.
- Backpressure and spurious done: hold `res_ready`=0 for 10 cycles in REPORT while pulsing `alu_done` with `alu_result`=0xF.
  - `res_data` stays at its captured value and no new `alu_start` occurs.
  - Release `res_ready`: the next command issues 2 cycles later.
- Reset mid-WAIT with 2 entries queued: assert `rst` asynchronously.
  - All outputs are 0 immediately and `busy`=0.
  - After release, no `alu_start` occurs until a new push.
- Done and timeout coincident: `alu_done` at WAIT edge 15 with `alu_result`=0x3.
  - `res_timeout`=0, `res_data`=0x3.
